// File: rtl/program_sequencer_verilog_pkg.sv
`default_nettype none
// ============================================================================
// Module      : program_sequencer_verilog_pkg
// Description : Shared state encoding, control-class opcodes and helpers for
//               the program sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package program_sequencer_verilog_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_WAIT   = 3'd2,
    ST_ISSUE  = 3'd3,
    ST_HALTED = 3'd4
  } state_t;

  // Operator class owned by the sequencer; every other class goes to the datapath.
  localparam logic [3:0] c_class_ctrl = 4'hF;

  // Control sub-operations carried in operator[11:8].
  localparam logic [3:0] c_subop_nop  = 4'h0;
  localparam logic [3:0] c_subop_jmp  = 4'h1;
  localparam logic [3:0] c_subop_brf  = 4'h2;
  localparam logic [3:0] c_subop_brnf = 4'h3;
  localparam logic [3:0] c_subop_halt = 4'hF;

  // True when an operator class is forwarded to the datapath.
  function automatic logic f_is_issue(input logic [3:0] i_cls);
    return (i_cls != c_class_ctrl);
  endfunction

endpackage
`default_nettype wire

// File: rtl/program_sequencer_verilog_decode.sv
`default_nettype none
// ============================================================================
// Module      : program_sequencer_verilog_decode
// Description : Combinational next-PC / halt decode of the registered
//               instruction fields (jump, flag branches, halt).
// Revision    : 1.0 - initial release
// ============================================================================
module program_sequencer_verilog_decode
  import program_sequencer_verilog_pkg::*;
#(
  parameter int PC_WIDTH = 8
) (
  input  logic [3:0]          i_class,
  input  logic [3:0]          i_subop,
  input  logic [1:0]          i_flag_sel,
  input  logic [PC_WIDTH-1:0] i_target,
  input  logic [3:0]          i_flags,
  input  logic [PC_WIDTH-1:0] i_pc,
  output logic [PC_WIDTH-1:0] o_next_pc,
  output logic                o_is_halt
);

  logic [PC_WIDTH-1:0] w_pc_inc;
  logic                w_flag;

  // Sequential fall-through wraps modulo 2^PC_WIDTH.
  assign w_pc_inc = i_pc + PC_WIDTH'(1);
  assign w_flag   = i_flags[i_flag_sel];

  // Select the next PC; unknown control sub-ops fall through like NOP.
  always_comb begin
    o_next_pc = w_pc_inc;
    o_is_halt = 1'b0;
    if (i_class == c_class_ctrl) begin
      case (i_subop)
        c_subop_jmp:  o_next_pc = i_target;
        c_subop_brf:  if (w_flag)  o_next_pc = i_target;
        c_subop_brnf: if (!w_flag) o_next_pc = i_target;
        c_subop_halt: begin
          o_next_pc = i_pc;
          o_is_halt = 1'b1;
        end
        default:      o_next_pc = w_pc_inc;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/program_sequencer_verilog.sv
`default_nettype none
// ============================================================================
// Module      : program_sequencer_verilog
// Description : Instruction fetch/issue sequencer. Fetches from a synchronous
//               ROM (one cycle latency), issues datapath ops for one cycle,
//               executes jump/branch/halt locally and counts retirements.
// Revision    : 1.0 - initial release
// ============================================================================
module program_sequencer_verilog
  import program_sequencer_verilog_pkg::*;
#(
  parameter int DATA_WIDTH    = 16,
  parameter int PC_WIDTH      = 8,
  parameter int RETIRED_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_start,
  output logic [PC_WIDTH-1:0]     o_instr_addr,
  input  logic [2*DATA_WIDTH-1:0] i_instr_data,
  input  logic [3:0]              i_alu_flags,
  output logic [DATA_WIDTH-1:0]   o_operator,
  output logic [DATA_WIDTH-1:0]   o_operand,
  output logic [PC_WIDTH-1:0]     o_pc,
  output logic                    o_busy,
  output logic                    o_halted,
  output logic [RETIRED_WIDTH-1:0] o_retired
);

  // Datapath ignores class-F operators, so this is driven whenever nothing issues.
  localparam logic [DATA_WIDTH-1:0] c_nop_operator = {4'hF, {(DATA_WIDTH-4){1'b0}}};

  state_t                   r_state;
  logic [PC_WIDTH-1:0]      r_pc;
  logic [RETIRED_WIDTH-1:0] r_retired;
  logic [DATA_WIDTH-1:0]    r_operator;
  logic [DATA_WIDTH-1:0]    r_operand;
  logic [3:0]               r_class;
  logic [3:0]               r_subop;
  logic [1:0]               r_flag_sel;
  logic [PC_WIDTH-1:0]      r_target;

  logic [3:0]               w_rom_class;
  logic [PC_WIDTH-1:0]      w_next_pc;
  logic                     w_is_halt;

  assign w_rom_class = i_instr_data[2*DATA_WIDTH-1 -: 4];

  program_sequencer_verilog_decode #(
    .PC_WIDTH (PC_WIDTH)
  ) u_decode (
    .i_class    (r_class),
    .i_subop    (r_subop),
    .i_flag_sel (r_flag_sel),
    .i_target   (r_target),
    .i_flags    (i_alu_flags),
    .i_pc       (r_pc),
    .o_next_pc  (w_next_pc),
    .o_is_halt  (w_is_halt)
  );

  // Main FSM: state, PC, retire counter and the registered issue outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_pc       <= '0;
      r_retired  <= '0;
      r_operator <= c_nop_operator;
      r_operand  <= '0;
      r_class    <= c_class_ctrl;
      r_subop    <= c_subop_nop;
      r_flag_sel <= '0;
      r_target   <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_HALTED: begin
          if (i_start) begin
            r_state   <= ST_FETCH;
            r_pc      <= '0;
            r_retired <= '0;
          end
        end
        ST_FETCH: r_state <= ST_WAIT;
        ST_WAIT: begin
          // ROM word is valid now; load the outputs so they show during ISSUE.
          r_class    <= w_rom_class;
          r_subop    <= i_instr_data[2*DATA_WIDTH-5 -: 4];
          r_flag_sel <= i_instr_data[DATA_WIDTH+1:DATA_WIDTH];
          r_target   <= i_instr_data[PC_WIDTH-1:0];
          if (f_is_issue(w_rom_class)) begin
            r_operator <= i_instr_data[2*DATA_WIDTH-1:DATA_WIDTH];
            r_operand  <= i_instr_data[DATA_WIDTH-1:0];
          end else begin
            r_operator <= c_nop_operator;
            r_operand  <= '0;
          end
          r_state <= ST_ISSUE;
        end
        ST_ISSUE: begin
          r_operator <= c_nop_operator;
          r_operand  <= '0;
          r_pc       <= w_next_pc;
          if (r_retired != '1) r_retired <= r_retired + RETIRED_WIDTH'(1);
          r_state    <= w_is_halt ? ST_HALTED : ST_FETCH;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_instr_addr = r_pc;
  assign o_pc         = r_pc;
  assign o_operator   = r_operator;
  assign o_operand    = r_operand;
  assign o_retired    = r_retired;
  assign o_busy       = (r_state == ST_FETCH) || (r_state == ST_WAIT) || (r_state == ST_ISSUE);
  assign o_halted     = (r_state == ST_HALTED);

endmodule
`default_nettype wire

// File: tb/tb_program_sequencer_verilog.sv
`default_nettype none
// ============================================================================
// Module      : tb_program_sequencer_verilog
// Description : Directed scoreboard bench for the program sequencer. A second
//               instance with a 4-bit retire counter exercises saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_program_sequencer_verilog;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  flags;
  logic [7:0]  addr, pc, addr_s, pc_s;
  logic [31:0] rom_q, rom_q_s;
  logic [15:0] op, opd, ret, op_s, opd_s;
  logic [3:0]  ret_s;
  logic        busy, halted, busy_s, halted_s;

  logic [31:0] rom [256];

  typedef struct packed {
    logic [7:0]  a;
    logic [31:0] w;
  } exp_t;
  exp_t q[$];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Synchronous ROMs: data appears the cycle after the address.
  always @(posedge clk) begin
    rom_q   <= rom[addr];
    rom_q_s <= rom[addr_s];
  end

  program_sequencer_verilog #(.DATA_WIDTH(16), .PC_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .i_start(start), .o_instr_addr(addr),
    .i_instr_data(rom_q), .i_alu_flags(flags), .o_operator(op),
    .o_operand(opd), .o_pc(pc), .o_busy(busy), .o_halted(halted),
    .o_retired(ret)
  );

  program_sequencer_verilog #(.DATA_WIDTH(16), .PC_WIDTH(8), .RETIRED_WIDTH(4)) dut_s (
    .clk(clk), .reset(reset), .i_start(start), .o_instr_addr(addr_s),
    .i_instr_data(rom_q_s), .i_alu_flags(flags), .o_operator(op_s),
    .o_operand(opd_s), .o_pc(pc_s), .o_busy(busy_s), .o_halted(halted_s),
    .o_retired(ret_s)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_nop();
    for (int i = 0; i < 256; i++) rom[i] = 32'hF000_0000;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Expected issue word: datapath classes pass through, control shows NOP.
  task automatic push(input logic [7:0] a, input logic [31:0] w);
    exp_t e;
    e.a = a;
    e.w = (w[31:28] != 4'hF) ? w : 32'hF000_0000;
    q.push_back(e);
  endtask

  // Entered in a FETCH cycle; consumes one FETCH/WAIT/ISSUE triple per entry.
  task automatic drain(input int base);
    int   k;
    exp_t e;
    k = base;
    while (q.size() > 0) begin
      e = q.pop_front();
      chk("fetch_addr", addr, e.a);
      chk("retired", ret, k);
      chk("retired_sat", ret_s, (k > 15) ? 15 : k);
      chk("busy_fetch", busy, 1);
      tick();
      chk("wait_nop", {op, opd}, 32'hF000_0000);
      tick();
      chk("issue", {op, opd}, e.w);
      tick();
      k++;
    end
  endtask

  task automatic run_branch(input logic [31:0] w, input logic [3:0] f, input logic [7:0] exp_a);
    fill_nop();
    rom[0]  = w;
    rom[1]  = 32'hFF00_0000;
    rom[16] = 32'hFF00_0000;
    flags   = f;
    pulse_start();
    push(8'd0, w);
    push(exp_a, 32'hFF00_0000);
    drain(0);
    chk("branch_halted", halted, 1);
    chk("branch_pc", pc, exp_a);
  endtask

  // Directed sequence.
  initial begin
    reset = 1'b0;
    start = 1'b0;
    flags = 4'b0000;
    fill_nop();
    tick();
    tick();
    chk("rst_operator", op, 16'hF000);
    chk("rst_operand", opd, 16'h0000);
    chk("rst_addr", addr, 8'h00);
    chk("rst_pc", pc, 8'h00);
    chk("rst_busy", busy, 0);
    chk("rst_halted", halted, 0);
    chk("rst_retired", ret, 0);
    reset = 1'b1;
    tick();

    // ALU op then HALT.
    rom[0] = 32'h1003_00AA;
    rom[1] = 32'hFF00_0000;
    pulse_start();
    push(8'd0, 32'h1003_00AA);
    push(8'd1, 32'hFF00_0000);
    drain(0);
    chk("a_halted", halted, 1);
    chk("a_busy", busy, 0);
    chk("a_retired", ret, 2);
    chk("a_pc", pc, 1);
    tick();
    chk("a_hold_halted", halted, 1);
    chk("a_hold_retired", ret, 2);

    // Restart from HALTED into a JMP.
    fill_nop();
    rom[0] = 32'hF100_0005;
    rom[5] = 32'hFF00_0000;
    pulse_start();
    chk("restart_pc", pc, 0);
    chk("restart_retired", ret, 0);
    chk("restart_busy", busy, 1);
    push(8'd0, 32'hF100_0005);
    push(8'd5, 32'hFF00_0000);
    drain(0);
    chk("jmp_retired", ret, 2);
    chk("jmp_halted", halted, 1);

    // Flag branches.
    run_branch(32'hF200_0010, 4'b0001, 8'h10);
    run_branch(32'hF200_0010, 4'b0000, 8'h01);
    run_branch(32'hF300_0010, 4'b0001, 8'h01);
    run_branch(32'hF300_0010, 4'b0000, 8'h10);
    run_branch(32'hF201_0010, 4'b0001, 8'h01);
    run_branch(32'hF202_0010, 4'b0100, 8'h10);
    run_branch(32'hF303_0010, 4'b0111, 8'h10);
    flags = 4'b0000;

    // Mixed classes, including an undefined control sub-op.
    fill_nop();
    rom[0] = 32'h0123_4567;
    rom[1] = 32'hF500_0009;
    rom[2] = 32'hE000_FFFF;
    rom[3] = 32'hFF00_0000;
    pulse_start();
    for (int i = 0; i < 4; i++) push(8'(i), rom[i]);
    drain(0);
    chk("mix_pc", pc, 3);
    chk("mix_retired", ret, 4);

    // PC wrap through 255 and retire-count saturation on the narrow instance.
    fill_nop();
    rom[2] = 32'hF100_00FF;
    pulse_start();
    for (int i = 0; i < 300; i++) begin
      case (i % 4)
        0: push(8'd0, 32'hF000_0000);
        1: push(8'd1, 32'hF000_0000);
        2: push(8'd2, 32'hF100_00FF);
        default: push(8'd255, 32'hF000_0000);
      endcase
    end
    drain(0);
    chk("wrap_addr", addr, 0);
    chk("wrap_retired", ret, 300);
    chk("wrap_sat", ret_s, 4'hF);

    // Reset asserted during WAIT aborts without an issue pulse.
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    fill_nop();
    rom[0] = 32'h1234_5678;
    pulse_start();
    tick();
    reset = 1'b0;
    tick();
    chk("wrst_operator", op, 16'hF000);
    chk("wrst_operand", opd, 16'h0000);
    chk("wrst_busy", busy, 0);
    chk("wrst_halted", halted, 0);
    chk("wrst_pc", pc, 0);
    chk("wrst_retired", ret, 0);
    reset = 1'b1;
    tick();
    chk("wrst_no_issue", {op, opd}, 32'hF000_0000);
    chk("wrst_idle", busy, 0);
    tick();
    chk("wrst_still_idle", busy, 0);

    // Start pulses during FETCH and ISSUE are ignored.
    rom[0] = 32'h1111_2222;
    rom[1] = 32'h2222_3333;
    rom[2] = 32'hFF00_0000;
    pulse_start();
    chk("ign_fetch_addr", addr, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("ign_wait_busy", busy, 1);
    chk("ign_wait_nop", op, 16'hF000);
    tick();
    chk("ign_issue", {op, opd}, 32'h1111_2222);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("ign_pc", pc, 1);
    chk("ign_retired", ret, 1);
    push(8'd1, 32'h2222_3333);
    push(8'd2, 32'hFF00_0000);
    drain(1);
    chk("ign_halted", halted, 1);
    chk("ign_final_retired", ret, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/program_sequencer_verilog.md
# program_sequencer_verilog

Upstream instruction stage for the 16-bit ALU/register datapath. It fetches 32-bit instruction words from an external synchronous program ROM and presents each ALU or immediate-write instruction on `operator`/`operand` for exactly one cycle. It executes the control-class instructions itself (jump, conditional branch on `alu_flags`, halt) and counts retired instructions.

## Interface
- `DATA_WIDTH`, 16, width of `operator`/`operand`; instruction word is 2×`DATA_WIDTH`
- `PC_WIDTH`, 8, program counter and ROM address width
- `clk`  in  1  clock, rising edge
- `reset`  in  1  synchronous, active-low reset, single clock `clk`
- `start`  in  1  one-cycle pulse; starts execution at PC 0 from IDLE or HALTED
- `instr_addr`  out  PC_WIDTH  ROM address; ROM returns data one cycle later
- `instr_data`  in  2×DATA_WIDTH  ROM word: [31:16] operator, [15:0] operand
- `alu_flags`  in  4  from ALU: [0] zero, [1] carry, [2] negative, [3] overflow
- `operator`  out  DATA_WIDTH  to datapath; NOP value 16'hF000 when not issuing
- `operand`  out  DATA_WIDTH  to datapath; 0 when not issuing
- `pc`  out  PC_WIDTH  current program counter
- `busy`  out  1  high in FETCH/WAIT/ISSUE
- `halted`  out  1  high in HALTED
- `retired`  out  16  instructions completed since start, saturating at 16'hFFFF

## Operation
- States: IDLE, FETCH, WAIT, ISSUE, HALTED.
- IDLE: `start`=1 → FETCH, pc←0, retired←0. All other inputs ignored.
- FETCH: drive `instr_addr`=pc → WAIT.
- WAIT: ROM latency cycle; register `instr_data` at end of cycle → ISSUE.
- ISSUE: decode the registered word. Class = operator[15:12].
  - Class ≠ 4'hF: drive `operator`/`operand` from the word for this one cycle (datapath acts on this edge); pc←pc+1.
  - Class 4'hF (control), sub-op operator[11:8]; outputs remain NOP:
    - 0 NOP: pc←pc+1.
    - 1 JMP: pc←operand[PC_WIDTH-1:0].
    - 2 BRF: if alu_flags[operator[1:0]]=1 then pc←operand[PC_WIDTH-1:0], else pc+1.
    - 3 BRNF: branch if that flag bit is 0, else pc+1.
    - F HALT: pc unchanged → HALTED.
    - Other sub-ops: treated as NOP.
  - retired←retired+1 (saturating), HALT included. Next state FETCH unless HALT.
- HALTED: `start`=1 → FETCH, pc←0, retired←0. Otherwise hold.
- `start` in FETCH/WAIT/ISSUE is ignored.
- pc arithmetic is modulo 2^PC_WIDTH; address 255+1 wraps to 0 with no flag.
- Datapath never writes on class-F operators, so the NOP value is safe on every non-issue cycle.

## Timing
- Reset (reset=0 at a rising edge) gives: state IDLE, `operator`=16'hF000, `operand`=0, `instr_addr`=0, `pc`=0, `busy`=0, `halted`=0, `retired`=0.
- Reset mid-run aborts immediately. No partial instruction is issued after the reset edge.
- Each instruction takes 3 cycles: FETCH → WAIT → ISSUE.
- `operator`/`operand` are registered outputs, valid for exactly the ISSUE cycle.
- `start` at edge N: FETCH in cycle N+1. The first issue is visible in cycle N+3.
- Branch flags are sampled combinationally in ISSUE. They reflect the ALU op issued ≥3 cycles earlier; no extra interlock is needed.
- `busy`/`halted` are decoded from the registered state, with no combinational path from `start`.

## Structure
- Shared header `program_sequencer_defs.vh`: state encodings, CLASS_CTRL=4'hF, sub-op codes (NOP/JMP/BRF/BRNF/HALT), NOP_OPERATOR=16'hF000, flag bit indices.
- Class value 4'h0 = ALU op is owned by the datapath definitions; the sequencer only forwards it.
- One natural sub-module: `sequencer_decode` (combinational): registered word + flags + pc → next_pc, is_halt, issue_enable.
- The FSM and counters stay in the top module.

## Test plan
- Reset then start, ROM[0]=32'h1003_00AA, ROM[1]=32'hFF00_0000 → cycle 3 after start: operator=16'h1003, operand=16'h00AA for one cycle; then halted=1, retired=2, pc=1.
- ROM[0]=32'hF100_0005 (JMP 5), ROM[5]=HALT → instr_addr sequence 0, 5; operator stays 16'hF000 throughout; retired=2.
- BRF on zero: ROM[0]=32'hF200_0010, alu_flags=4'b0001 → next fetch addr 16'h10. Same with alu_flags=4'b0000 → next fetch addr 1. BRNF gives the inverse results.
- Wrap: ROM all NOP (32'hF000_0000) except ROM[2]=JMP 255; run 300 instructions → fetch after 255 is 0; then force retired near saturation → holds at 16'hFFFF.
- Reset asserted in WAIT → next cycle: outputs at reset values, state IDLE, no issue pulse. `start` pulses in FETCH/ISSUE are ignored: pc and retired unaffected.
- Restart from HALTED: start → pc=0, retired=0, fetch at address 0 on the next cycle.
